// File: rtl/seq_data_processor_pkg.sv
// Shared types and defaults for the sequence buffer:
// score width, symbol codes, buffer depths and FSM states.
package seq_data_processor_pkg;

  localparam int V_E_F_Bit = 12;
  localparam int S_MAX_DEF = 256;
  localparam int T_MAX_DEF = 1024;

  localparam logic [1:0] SYM_A = 2'd0;
  localparam logic [1:0] SYM_C = 2'd1;
  localparam logic [1:0] SYM_G = 2'd2;
  localparam logic [1:0] SYM_T = 2'd3;

  typedef enum logic [1:0] {
    LOAD_S = 2'd0,
    LOAD_T = 2'd1,
    READY  = 2'd2,
    RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/seq_data_processor_t_column_buffer.sv
// T column register file: one comb read port, one write port
// (host load or write-back), write-back wrap/pass counters, avail.
module t_column_buffer
  import seq_data_processor_pkg::*;
#(
  parameter int T_MAX   = T_MAX_DEF,
  parameter int VEF_BIT = V_E_F_Bit,
  parameter int PW      = 9,
  localparam int TAW    = $clog2(T_MAX),
  localparam int TLW    = TAW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               ld_we_i,
  input  logic [TAW-1:0]     ld_addr_i,
  input  logic [1:0]         ld_sym_i,
  input  logic               wb_en_i,
  input  logic [1:0]         wb_t_i,
  input  logic [VEF_BIT-1:0] wb_v_i,
  input  logic [VEF_BIT-1:0] wb_f_i,
  input  logic [TLW-1:0]     len_i,
  input  logic [TAW-1:0]     rd_ptr_i,
  input  logic [PW-1:0]      pass_i,
  output logic [1:0]         rd_t_o,
  output logic [VEF_BIT-1:0] rd_v_o,
  output logic [VEF_BIT-1:0] rd_f_o,
  output logic               avail_o
);

  logic [1:0]         t_mem [T_MAX];
  logic [VEF_BIT-1:0] v_mem [T_MAX];
  logic [VEF_BIT-1:0] f_mem [T_MAX];

  logic [TAW-1:0] wb_ptr_q, wb_ptr_d;
  logic [PW-1:0]  wb_pass_q, wb_pass_d;
  logic [TAW-1:0] w_addr;
  logic [1:0]     w_t;
  logic [VEF_BIT-1:0] w_v, w_f;
  logic           wb_last;
  logic [PW-1:0]  pm1;

  // Load and write-back never overlap (state-gated in the top).
  always_comb begin
    w_addr = ld_addr_i;
    w_t    = ld_sym_i;
    w_v    = '0;
    w_f    = '0;
    if (wb_en_i) begin
      w_addr = wb_ptr_q;
      w_t    = wb_t_i;
      w_v    = wb_v_i;
      w_f    = wb_f_i;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we_i || wb_en_i) begin
      t_mem[w_addr] <= w_t;
      v_mem[w_addr] <= w_v;
      f_mem[w_addr] <= w_f;
    end
  end

  assign wb_last = ({1'b0, wb_ptr_q} == len_i - TLW'(1));

  always_comb begin
    wb_ptr_d  = wb_ptr_q;
    wb_pass_d = wb_pass_q;
    if (clr_i) begin
      wb_ptr_d  = '0;
      wb_pass_d = '0;
    end else if (wb_en_i) begin
      if (wb_last) begin
        wb_ptr_d  = '0;
        wb_pass_d = wb_pass_q + PW'(1);
      end else begin
        wb_ptr_d  = wb_ptr_q + TAW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ptr_q  <= '0;
      wb_pass_q <= '0;
    end else begin
      wb_ptr_q  <= wb_ptr_d;
      wb_pass_q <= wb_pass_d;
    end
  end

  // An entry of pass p is readable once pass p-1 wrote it back;
  // a write in this cycle only counts from the next one.
  assign pm1     = pass_i - PW'(1);
  assign avail_o = (pass_i == '0) ||
                   (wb_pass_q > pm1) ||
                   ((wb_pass_q == pm1) && (wb_ptr_q > rd_ptr_i));

  assign rd_t_o = t_mem[rd_ptr_i];
  assign rd_v_o = v_mem[rd_ptr_i];
  assign rd_f_o = f_mem[rd_ptr_i];

endmodule

// File: rtl/seq_data_processor.sv
// S/T sequence buffer feeding the PE array controller: host load,
// per-word S/T streaming, T/V/F write-back across passes.
module seq_data_processor
  import seq_data_processor_pkg::*;
#(
  parameter int S_MAX   = S_MAX_DEF,
  parameter int T_MAX   = T_MAX_DEF,
  parameter int VEF_BIT = V_E_F_Bit
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_valid,
  output logic               o_load_ready,
  input  logic [1:0]         i_load_sym,
  input  logic               i_load_last,
  input  logic               i_start,
  output logic               o_data_valid,
  input  logic               i_update_s_w,
  output logic [1:0]         o_s,
  output logic               o_s_last,
  input  logic               i_update_t_w,
  output logic [1:0]         o_t,
  output logic [VEF_BIT-1:0] o_v,
  output logic [VEF_BIT-1:0] o_f,
  output logic               o_t_last,
  input  logic               i_t_valid,
  input  logic [1:0]         i_t,
  input  logic [VEF_BIT-1:0] i_v,
  input  logic [VEF_BIT-1:0] i_f,
  output logic               o_done
);

  localparam int SAW = $clog2(S_MAX);
  localparam int SLW = SAW + 1;
  localparam int TAW = $clog2(T_MAX);
  localparam int TLW = TAW + 1;
  localparam int PW  = SAW + 1;

  state_e         state_q, state_d;
  logic [SAW-1:0] s_cnt_q, s_cnt_d;
  logic [TAW-1:0] t_cnt_q, t_cnt_d;
  logic [SLW-1:0] s_len_q, s_len_d;
  logic [TLW-1:0] t_len_q, t_len_d;
  logic [SAW-1:0] s_ptr_q, s_ptr_d;
  logic [TAW-1:0] t_ptr_q, t_ptr_d;
  logic [PW-1:0]  pass_q, pass_d;
  logic           s_exh_q, s_exh_d;

  logic [1:0] s_mem [S_MAX];

  logic s_we, t_we, wb_en, clr, avail;
  logic s_take, t_take, done;
  logic [1:0]         rd_t;
  logic [VEF_BIT-1:0] rd_v, rd_f;

  assign s_we  = (state_q == LOAD_S) && i_load_valid;
  assign t_we  = (state_q == LOAD_T) && i_load_valid;
  assign wb_en = i_t_valid &&
                 ((state_q == READY) || (state_q == RUN));
  assign clr   = (state_q == READY) && i_start;

  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_cnt_q] <= i_load_sym;
  end

  t_column_buffer #(
    .T_MAX   (T_MAX),
    .VEF_BIT (VEF_BIT),
    .PW      (PW)
  ) u_tbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .ld_we_i   (t_we),
    .ld_addr_i (t_cnt_q),
    .ld_sym_i  (i_load_sym),
    .wb_en_i   (wb_en),
    .wb_t_i    (i_t),
    .wb_v_i    (i_v),
    .wb_f_i    (i_f),
    .len_i     (t_len_q),
    .rd_ptr_i  (t_ptr_q),
    .pass_i    (pass_q),
    .rd_t_o    (rd_t),
    .rd_v_o    (rd_v),
    .rd_f_o    (rd_f),
    .avail_o   (avail)
  );

  assign o_load_ready = (state_q == LOAD_S) ||
                        (state_q == LOAD_T);
  assign o_data_valid = (state_q == RUN) && avail;

  assign o_s      = s_mem[s_ptr_q];
  assign o_s_last = ({1'b0, s_ptr_q} == s_len_q - SLW'(1));
  assign o_t      = rd_t;
  assign o_t_last = ({1'b0, t_ptr_q} == t_len_q - TLW'(1));
  // Pass 0 starts from a zero boundary column.
  assign o_v      = (pass_q == '0) ? '0 : rd_v;
  assign o_f      = (pass_q == '0) ? '0 : rd_f;

  assign s_take = o_data_valid && i_update_s_w;
  assign t_take = o_data_valid && i_update_t_w;
  assign done   = t_take && o_t_last &&
                  (s_exh_q || (s_take && o_s_last));
  assign o_done = done;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    t_cnt_d = t_cnt_q;
    s_len_d = s_len_q;
    t_len_d = t_len_q;
    s_ptr_d = s_ptr_q;
    t_ptr_d = t_ptr_q;
    pass_d  = pass_q;
    s_exh_d = s_exh_q;
    unique case (state_q)
      LOAD_S: begin
        if (s_we) begin
          s_cnt_d = s_cnt_q + SAW'(1);
          if (i_load_last || s_cnt_q == SAW'(S_MAX - 1)) begin
            s_len_d = {1'b0, s_cnt_q} + SLW'(1);
            s_cnt_d = '0;
            t_cnt_d = '0;
            state_d = LOAD_T;
          end
        end
      end
      LOAD_T: begin
        if (t_we) begin
          t_cnt_d = t_cnt_q + TAW'(1);
          if (i_load_last || t_cnt_q == TAW'(T_MAX - 1)) begin
            t_len_d = {1'b0, t_cnt_q} + TLW'(1);
            t_cnt_d = '0;
            state_d = READY;
          end
        end
      end
      READY: begin
        if (i_start) begin
          s_ptr_d = '0;
          t_ptr_d = '0;
          pass_d  = '0;
          s_exh_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // S pointer saturates on its last symbol.
        if (s_take) begin
          if (o_s_last) s_exh_d = 1'b1;
          else          s_ptr_d = s_ptr_q + SAW'(1);
        end
        if (t_take) begin
          if (o_t_last) begin
            t_ptr_d = '0;
            pass_d  = pass_q + PW'(1);
          end else begin
            t_ptr_d = t_ptr_q + TAW'(1);
          end
        end
        if (done) state_d = LOAD_S;
      end
      default: state_d = LOAD_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_S;
      s_cnt_q <= '0;
      t_cnt_q <= '0;
      s_len_q <= '0;
      t_len_q <= '0;
      s_ptr_q <= '0;
      t_ptr_q <= '0;
      pass_q  <= '0;
      s_exh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      t_cnt_q <= t_cnt_d;
      s_len_q <= s_len_d;
      t_len_q <= t_len_d;
      s_ptr_q <= s_ptr_d;
      t_ptr_q <= t_ptr_d;
      pass_q  <= pass_d;
      s_exh_q <= s_exh_d;
    end
  end

endmodule
